// File: rtl/img_row_streamer_pkg.sv
// Shared constants, FSM state encoding and pixel type for the image row streamer.
package img_pkg;
  localparam int ADDR_W      = 9;
  localparam int ROW_W       = 640;
  localparam int PIX_W       = 8;
  localparam int PIX_PER_ROW = ROW_W / PIX_W;
  localparam int IDX_W       = 7;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/img_row_streamer_if.sv
// Pixel stream from the row streamer to the coprocessor pipeline.
interface img_row_streamer_if;
  import img_pkg::*;

  // A pixel moves on every clock where pix_valid and pix_ready are both high.
  // Once pix_valid rises, it and pix_data/pix_eol/pix_eof hold until that transfer.
  pix_t pix_data;
  logic pix_valid;
  logic pix_ready;
  logic pix_eol;
  logic pix_eof;

  modport master (output pix_data, pix_valid, pix_eol, pix_eof, input pix_ready);
  modport slave  (input pix_data, pix_valid, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/img_row_serializer.sv
// Shift register plus one-row prefetch buffer; emits a row LSB byte first.
module img_row_serializer
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROW_W-1:0] row_in,
  input  logic             row_we,
  input  logic             accept,
  output pix_t             pix,
  output logic             valid,
  output logic             eol,
  output logic             pf_valid
);
  logic [ROW_W-1:0] shreg;
  logic [ROW_W-1:0] pf_row;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             last;

  assign xfer = valid & accept;
  assign last = xfer & (idx == IDX_W'(PIX_PER_ROW - 1));
  assign pix  = shreg[PIX_W-1:0];
  assign eol  = valid & (idx == IDX_W'(PIX_PER_ROW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      pf_row   <= '0;
      idx      <= '0;
      valid    <= 1'b0;
      pf_valid <= 1'b0;
    end else begin
      if (last) begin
        idx <= '0;
        if (pf_valid) begin
          shreg    <= pf_row;
          pf_valid <= 1'b0;
        end else if (row_we) begin
          shreg <= row_in;
        end else begin
          valid <= 1'b0;
        end
      end else if (xfer) begin
        shreg <= shreg >> PIX_W;
        idx   <= idx + 1'b1;
      end
      // Arriving row not already consumed by the row change above
      if (row_we && !(last && !pf_valid)) begin
        if (!valid) begin
          shreg <= row_in;
          valid <= 1'b1;
          idx   <= '0;
        end else begin
          pf_row   <= row_in;
          pf_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/img_row_streamer.sv
// Fetches num_rows buffer rows from base_row and streams them as 8-bit pixels.
module img_row_streamer
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [ADDR_W:0]   num_rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] raddr,
  input  logic [ROW_W-1:0]  rdata,
  img_row_streamer_if.master stream,
  output state_t            fsm_state
);
  state_t            state;
  state_t            state_nx;
  logic              rd_pend;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   rows_left;
  logic              ser_valid;
  logic              ser_eol;
  logic              pf_valid;
  logic              xfer;
  logic              issue;
  logic              job_go;
  logic              final_row;

  img_row_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (rdata),
    .row_we   (rd_pend),
    .accept   (stream.pix_ready),
    .pix      (stream.pix_data),
    .valid    (ser_valid),
    .eol      (ser_eol),
    .pf_valid (pf_valid)
  );

  assign final_row        = (rows_left == (ADDR_W+1)'(1));
  assign stream.pix_valid = ser_valid;
  assign stream.pix_eol   = ser_eol;
  assign stream.pix_eof   = ser_eol & final_row;
  assign xfer             = ser_valid & stream.pix_ready;
  assign job_go           = (state == IDLE) & start & (num_rows != '0);
  // One read in flight and one row parked at most: issue only when both slots are free
  assign issue            = (state == STREAM) & (issue_left != '0) & ~rd_pend & ~pf_valid;
  assign fsm_state        = state;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = (num_rows == '0) ? DONE : FILL;
      FILL: begin
        busy = 1'b1;
        if (rd_pend) state_nx = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (xfer && ser_eol && final_row) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      raddr      <= '0;
      rd_pend    <= 1'b0;
      issue_left <= '0;
      rows_left  <= '0;
    end else begin
      state <= state_nx;
      if (job_go) begin
        raddr      <= base_row;
        rd_pend    <= 1'b1;
        issue_left <= num_rows - 1'b1;
      end else if (issue) begin
        raddr      <= raddr + 1'b1;
        rd_pend    <= 1'b1;
        issue_left <= issue_left - 1'b1;
      end else begin
        rd_pend <= 1'b0;
      end
      if (job_go) rows_left <= num_rows;
      else if (xfer && ser_eol) rows_left <= rows_left - 1'b1;
    end
  end
endmodule

// File: doc/img_row_streamer.md
Name: img_row_streamer

Overview:
- Read-side consumer of the 512-row x 640-bit image buffer.
- On `start`, fetches `num_rows` consecutive rows beginning at `base_row` through the buffer's synchronous read port.
- Serializes each row into 80 8-bit pixels on a valid/ready stream feeding the image coprocessor pipeline.
- Prefetches the next row while the current one drains, so the stream is gap-free under full `pix_ready`.

Parameters:
- ADDR_W, 9, row address width (512 rows).
- ROW_W, 640, bits per buffer row.
- PIX_W, 8, bits per output pixel.
- PIX_PER_ROW, 80, ROW_W/PIX_W; must divide exactly.

Ports:
- clk  in  1  single clock for the block and the buffer.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_row  in  ADDR_W  first row address; sampled with start.
- num_rows  in  ADDR_W+1  rows to stream, 0..512; sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at job end.
- raddr  out  ADDR_W  registered read address to the buffer.
- rdata  in  ROW_W  buffer read data; valid one clock after raddr.
- pix_data  out  PIX_W  current pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts; transfer = pix_valid & pix_ready.
- pix_eol  out  1  qualifies the last pixel of a row (index 79).
- pix_eof  out  1  qualifies the last pixel of the job.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0; FSM enters IDLE; pixel count, row counters, prefetch-valid and read-pending flags clear.
- IDLE:
  - start with num_rows=0: done pulses on the next cycle; busy stays 0; no reads are issued.
  - start with num_rows>0: at that edge raddr<=base_row, rd_pend<=1, busy<=1, go to FILL.
- Read timing:
  - rdata is captured exactly one edge after the edge that set raddr with rd_pend=1.
  - rdata is ignored in all other cycles, because the buffer read port is free-running.
- FILL: captured rdata loads the shift register. From that cycle pix_valid=1, i.e. the first pixel is valid two edges after the start edge. Go to STREAM.
- Addressing: each new read issues raddr<=raddr+1, wrapping modulo 512 (510, 511, 0, 1, ...).
- Prefetch:
  - When a row is loaded into the shift register and rows remain unissued, the next read issues at the following edge.
  - The returning data goes into a prefetch register; pf_valid<=1.
  - At most one read is outstanding, and at most one row sits in the prefetch register.
- Pixel order: pixel i = row[i*8 +: 8]. Pixel 0 is the LSB byte; on each transfer the shift register shifts right by PIX_W.
- Row change:
  - On transfer of pixel 79 with pf_valid=1, the prefetch row loads into the shift register in the same edge. There is no bubble.
  - If pf_valid=0 at that point (only possible under pathological timing), pix_valid drops until the data arrives.
- pix_eol=1 when pixel index=79. pix_eof=1 when pix_eol=1 and this is the final row.
- Job end: the transfer with pix_eof=1 moves the FSM to DONE. In DONE, pix_valid=0, done=1 for exactly one cycle and busy falls with it; return to IDLE.
- Backpressure:
  - pix_data, pix_eol and pix_eof hold stable while pix_valid=1 and pix_ready=0.
  - pix_valid never deasserts without a transfer, except on reset.
- start while busy is ignored; base_row and num_rows are not re-sampled.
- Reset mid-stream aborts immediately: no done pulse; the next start begins a fresh job.
- num_rows=512 with any base_row covers each row exactly once.

Decomposition:
- Package img_pkg holds:
  - constants ADDR_W, ROW_W, PIX_W, PIX_PER_ROW;
  - the FSM enum typedef {IDLE, FILL, STREAM, DONE};
  - typedef pix_t = logic [PIX_W-1:0].
- One natural sub-module, img_row_serializer:
  - contents: shift register, prefetch register, 7-bit pixel index, eol generation;
  - load/shift/accept interface;
  - the top level keeps the FSM, address counter, row counter and read-pending tracking.

Test Plan:
- Single row: buffer row 3 = bytes 0x00..0x4F LSB-first; start base_row=3, num_rows=1, pix_ready=1. Required response:
  - first pix_valid 2 cycles after start;
  - 80 pixels 0x00..0x4F on consecutive cycles;
  - pix_eol and pix_eof on 0x4F;
  - done pulses 1 cycle after.
- Gap-free multi-row: num_rows=4, pix_ready=1 → 320 consecutive pix_valid cycles, no bubble; pix_eol at pixels 79/159/239/319.
- Wrap-around: base_row=510, num_rows=4 → raddr sequence 510, 511, 0, 1; the data order matches the rows.
- Backpressure: pix_ready toggles pseudo-randomly (50%) over 3 rows → every pixel is delivered once, in order; outputs stay stable while stalled.
- Corner cases:
  - num_rows=0 → done pulses the next cycle, no pix_valid, no raddr change;
  - start asserted mid-job → ignored, and the job completes unchanged.
- Reset mid-stream: rst_n low at pixel 40 of row 2 → all outputs are 0 asynchronously; no done pulse; a new start with base_row=0, num_rows=1 then streams correctly.
